// File: rtl/pc_sequencer.sv
// Fetch/execute sequencer and next-PC generator for the 6-bit program counter.
// Free-run and single-step modes, stalls, relative branches, HALT and a retire counter.
module pc_sequencer #(
    parameter int unsigned PC_W     = 6,
    parameter int unsigned RESET_PC = 32,
    parameter int unsigned CNT_W    = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_run,
    input  logic             i_step,
    input  logic             i_stall,
    input  logic [PC_W-1:0]  i_pc_cur,
    input  logic             i_is_branch,
    input  logic             i_is_cond,
    input  logic             i_cond_true,
    input  logic             i_is_halt,
    input  logic [PC_W-1:0]  i_br_offset,
    output logic             o_ir_we,
    output logic             o_exec_en,
    output logic             o_pc_we,
    output logic [PC_W-1:0]  o_pc_next,
    output logic             o_halted,
    output logic [1:0]       o_state,
    output logic [CNT_W-1:0] o_instr_cnt
);

    // The PC register itself lives outside; RESET_PC must still be a legal address.
    if (RESET_PC >= (64'd1 << PC_W)) begin : g_bad_reset_pc
        $error("RESET_PC does not fit in PC_W bits");
    end

    typedef enum logic [1:0] {
        StFetch    = 2'b00,
        StExec     = 2'b01,
        StWaitStep = 2'b10,
        StHalt     = 2'b11
    } state_e;

    state_e           r_state;
    state_e           w_state_next;
    logic             r_step_q;
    logic [CNT_W-1:0] r_instr_cnt;
    logic             w_step_rise;
    logic             w_taken;
    logic [PC_W-1:0]  w_pc_inc;

    assign w_step_rise = i_step & ~r_step_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= StFetch;
            r_step_q    <= 1'b0;
            r_instr_cnt <= '0;
        end else begin
            r_state  <= w_state_next;
            r_step_q <= i_step;
            if (o_exec_en) begin
                r_instr_cnt <= r_instr_cnt + CNT_W'(1);
            end
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            StFetch: begin
                if (!i_stall) w_state_next = StExec;
            end
            StExec: begin
                if (!i_stall) begin
                    if (i_is_halt)  w_state_next = StHalt;
                    else if (i_run) w_state_next = StFetch;
                    else            w_state_next = StWaitStep;
                end
            end
            StWaitStep: begin
                // Only a fresh step edge advances; a held button retires one instruction.
                if (i_run || w_step_rise) w_state_next = StFetch;
            end
            StHalt: begin
                w_state_next = StHalt;
            end
            default: begin
                w_state_next = StFetch;
            end
        endcase
    end

    assign o_ir_we   = (r_state == StFetch) & ~i_stall & ~reset;
    assign o_exec_en = (r_state == StExec) & ~i_stall & ~reset;
    assign o_pc_we   = o_exec_en & ~i_is_halt;
    assign o_halted  = (r_state == StHalt) & ~reset;
    assign o_state   = r_state;

    assign o_instr_cnt = r_instr_cnt;

    // Modulo-2^PC_W arithmetic; a negative offset is just its two's-complement bit pattern.
    assign w_taken   = i_is_branch & (~i_is_cond | i_cond_true);
    assign w_pc_inc  = i_pc_cur + PC_W'(1);
    assign o_pc_next = w_taken ? (w_pc_inc + i_br_offset) : w_pc_inc;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer with a small PC register model feeding pc_cur back.
module tb_pc_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        run, step, stall;
    logic        is_branch, is_cond, cond_true, is_halt;
    logic [5:0]  br_offset;
    logic [5:0]  pc_cur;
    logic        ir_we, exec_en, pc_we, halted;
    logic [5:0]  pc_next;
    logic [1:0]  state;
    logic [15:0] instr_cnt;

    logic [5:0]  pc_reg;
    logic        pc_ovr;
    logic [5:0]  pc_ovr_val;
    logic        pc_load;
    logic [5:0]  pc_load_val;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    // PC register model: reset to 32, written by pc_we, or preloaded by the bench.
    always @(posedge clk) begin
        if (reset)        pc_reg <= 6'd32;
        else if (pc_we)   pc_reg <= pc_next;
        else if (pc_load) pc_reg <= pc_load_val;
    end

    assign pc_cur = pc_ovr ? pc_ovr_val : pc_reg;

    pc_sequencer dut (
        .clk         (clk),
        .reset       (reset),
        .i_run       (run),
        .i_step      (step),
        .i_stall     (stall),
        .i_pc_cur    (pc_cur),
        .i_is_branch (is_branch),
        .i_is_cond   (is_cond),
        .i_cond_true (cond_true),
        .i_is_halt   (is_halt),
        .i_br_offset (br_offset),
        .o_ir_we     (ir_we),
        .o_exec_en   (exec_en),
        .o_pc_we     (pc_we),
        .o_pc_next   (pc_next),
        .o_halted    (halted),
        .o_state     (state),
        .o_instr_cnt (instr_cnt)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1; run = 1'b1; step = 1'b0; stall = 1'b0;
        is_branch = 1'b0; is_cond = 1'b0; cond_true = 1'b0; is_halt = 1'b0;
        br_offset = 6'd0; pc_ovr = 1'b0; pc_ovr_val = 6'd0;
        pc_load = 1'b0; pc_load_val = 6'd0;
        tick();
        tick();

        // Reset state
        check_eq("rst_ir_we", 32'(ir_we), 0);
        check_eq("rst_exec_en", 32'(exec_en), 0);
        check_eq("rst_pc_we", 32'(pc_we), 0);
        check_eq("rst_halted", 32'(halted), 0);
        check_eq("rst_state", 32'(state), 0);
        check_eq("rst_cnt", 32'(instr_cnt), 0);

        // 1: free-run, four plain instructions
        reset = 1'b0;
        #1;
        for (int i = 0; i < 4; i++) begin
            check_eq("run_fetch_ir_we", 32'(ir_we), 1);
            check_eq("run_fetch_pc_we", 32'(pc_we), 0);
            check_eq("run_fetch_pc", 32'(pc_cur), 32 + i);
            tick();
            check_eq("run_exec_pc_we", 32'(pc_we), 1);
            check_eq("run_exec_ir_we", 32'(ir_we), 0);
            check_eq("run_exec_pc_next", 32'(pc_next), 33 + i);
            tick();
        end
        check_eq("run_pc_end", 32'(pc_cur), 36);
        check_eq("run_cnt", 32'(instr_cnt), 4);
        check_eq("run_state", 32'(state), 0);

        // Taken branch through the FSM: 36 + 1 - 5 = 32
        tick();
        is_branch = 1'b1; br_offset = 6'b111011;
        #1;
        check_eq("br_fsm_pc_next", 32'(pc_next), 32);
        tick();
        is_branch = 1'b0; br_offset = 6'd0;
        check_eq("br_fsm_pc", 32'(pc_cur), 32);
        check_eq("br_fsm_cnt", 32'(instr_cnt), 5);

        // 2/3: combinational next-PC with forced pc_cur
        stall = 1'b1;
        pc_ovr = 1'b1; pc_ovr_val = 6'd40; is_branch = 1'b1; br_offset = 6'b111011;
        #1 check_eq("br_neg", 32'(pc_next), 36);
        br_offset = 6'd30;
        #1 check_eq("br_wrap", 32'(pc_next), 7);
        pc_ovr_val = 6'd20; is_cond = 1'b1; cond_true = 1'b0; br_offset = 6'd3;
        #1 check_eq("br_cond_false", 32'(pc_next), 21);
        cond_true = 1'b1;
        #1 check_eq("br_cond_true", 32'(pc_next), 24);
        is_branch = 1'b0; is_cond = 1'b0; cond_true = 1'b0; br_offset = 6'd0;
        pc_ovr_val = 6'd63;
        #1 check_eq("seq_wrap", 32'(pc_next), 0);
        pc_ovr = 1'b0;

        // Stall in FETCH holds and suppresses ir_we
        #1 check_eq("stall_fetch_ir_we", 32'(ir_we), 0);
        tick();
        check_eq("stall_fetch_state", 32'(state), 0);
        stall = 1'b0;
        tick();

        // 4: three stalled EXEC cycles, then one commit
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            check_eq("stall_exec_state", 32'(state), 1);
            check_eq("stall_exec_pc_we", 32'(pc_we), 0);
            check_eq("stall_exec_cnt", 32'(instr_cnt), 5);
            tick();
        end
        stall = 1'b0;
        #1 check_eq("stall_release_pc_we", 32'(pc_we), 1);
        tick();
        check_eq("stall_after_state", 32'(state), 0);
        check_eq("stall_after_pc", 32'(pc_cur), 33);
        check_eq("stall_after_cnt", 32'(instr_cnt), 6);

        // 5: single-step; step during FETCH/EXEC is ignored
        run = 1'b0; step = 1'b1;
        tick();
        tick();
        check_eq("ss_wait_state", 32'(state), 2);
        check_eq("ss_wait_cnt", 32'(instr_cnt), 7);
        tick();
        check_eq("ss_no_queue", 32'(state), 2);
        step = 1'b0;
        tick();
        step = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        step = 1'b0;
        #1;
        check_eq("ss_one_state", 32'(state), 2);
        check_eq("ss_one_cnt", 32'(instr_cnt), 8);
        check_eq("ss_one_pc", 32'(pc_cur), 35);

        // 6: HALT at 50
        pc_load = 1'b1; pc_load_val = 6'd50;
        tick();
        pc_load = 1'b0;
        check_eq("halt_pc_load", 32'(pc_cur), 50);
        check_eq("halt_pre_state", 32'(state), 2);
        is_halt = 1'b1; run = 1'b1;
        tick();
        check_eq("halt_fetch_ir_we", 32'(ir_we), 1);
        tick();
        check_eq("halt_exec_en", 32'(exec_en), 1);
        check_eq("halt_exec_pc_we", 32'(pc_we), 0);
        check_eq("halt_exec_halted", 32'(halted), 0);
        tick();
        check_eq("halt_halted", 32'(halted), 1);
        check_eq("halt_state", 32'(state), 3);
        check_eq("halt_cnt", 32'(instr_cnt), 9);
        for (int i = 0; i < 4; i++) begin
            run  = i[0];
            step = ~i[1];
            tick();
            check_eq("halt_hold_state", 32'(state), 3);
            check_eq("halt_hold_pc_we", 32'(pc_we), 0);
            check_eq("halt_hold_ir_we", 32'(ir_we), 0);
            check_eq("halt_hold_pc", 32'(pc_cur), 50);
        end
        check_eq("halt_hold_cnt", 32'(instr_cnt), 9);

        reset = 1'b1; run = 1'b1; step = 1'b0;
        #1 check_eq("halt_rst_halted", 32'(halted), 0);
        tick();
        check_eq("halt_rst_state", 32'(state), 0);
        check_eq("halt_rst_cnt", 32'(instr_cnt), 0);
        reset = 1'b0; is_halt = 1'b0;
        #1;
        check_eq("post_rst_ir_we", 32'(ir_we), 1);
        check_eq("post_rst_pc", 32'(pc_cur), 32);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
